// File: rtl/panel_out_shifter_if.sv
// Parallel-side bundle of the panel output shifter: the vector to mirror, the force
// request, frame status and the three 74HC595-style pin drives.
interface panel_out_shifter_if #(
    parameter int WIDTH = 82
);
    logic [WIDTH-1:0] data_i;
    logic             force_i;
    logic             busy_o;
    logic             done_o;
    logic             sclk_o;
    logic             sdata_o;
    logic             latch_o;

    modport master (
        output data_i, force_i,
        input  busy_o, done_o, sclk_o, sdata_o, latch_o
    );

    modport slave (
        input  data_i, force_i,
        output busy_o, done_o, sclk_o, sdata_o, latch_o
    );
endinterface

// File: rtl/panel_out_shifter.sv
// Serialises data_i MSB-first onto a 74HC595-style chain whenever it changes or on force.
// Define PANEL_OUT_PARITY_EN to append one even-parity bit after the payload.
module panel_out_shifter #(
    parameter int WIDTH   = 82,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    panel_out_shifter_if.slave bus
);
`ifdef PANEL_OUT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int             CNT_W     = $clog2(NBITS + 1);
    localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_FIRST = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_last_sent;
    logic [NBITS-2:0]   r_shreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [7:0]         r_presc;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_sdata;
    logic               r_latch;

    logic [NBITS-1:0]   w_frame;
    logic               w_start;
    logic               w_phase_end;

`ifdef PANEL_OUT_PARITY_EN
    assign w_frame = {bus.data_i, ^bus.data_i};
`else
    assign w_frame = bus.data_i;
`endif
    assign w_start     = (bus.data_i != r_last_sent) || bus.force_i;
    assign w_phase_end = (r_presc == DIV_LAST);

    // The entry edge into LOAD already presents the first bit, so the LOAD cycle is
    // the first cycle of that bit's low phase and the prescaler starts counting there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last_sent <= '0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_presc     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sclk      <= 1'b0;
            r_sdata     <= 1'b0;
            r_latch     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (w_start) begin
                        r_state     <= S_LOAD;
                        r_shreg     <= w_frame[NBITS-2:0];
                        r_last_sent <= bus.data_i;
                        r_bitcnt    <= BIT_FIRST;
                        r_busy      <= 1'b1;
                        r_sdata     <= w_frame[NBITS-1];
                        r_sclk      <= 1'b0;
                    end
                end
                S_LOAD, S_SHIFT: begin
                    r_state <= S_SHIFT;
                    if (!w_phase_end) begin
                        r_presc <= r_presc + 8'd1;
                    end else begin
                        r_presc <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bitcnt == '0) begin
                                r_state <= S_LATCH;
                                r_latch <= 1'b1;
                                r_sdata <= 1'b0;
                            end else begin
                                r_bitcnt <= r_bitcnt - 1'b1;
                                r_sdata  <= r_shreg[NBITS-2];
                                r_shreg  <= r_shreg << 1;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (!w_phase_end) begin
                        r_presc <= r_presc + 8'd1;
                    end else begin
                        r_presc <= '0;
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;
    assign bus.sclk_o  = r_sclk;
    assign bus.sdata_o = r_sdata;
    assign bus.latch_o = r_latch;
endmodule

// File: tb/tb_panel_out_shifter.sv
// Bench for panel_out_shifter: one CLK_DIV=4 and one CLK_DIV=1 instance, frames
// decoded from the pins and compared against a reference built from the frame rules.
module tb_panel_out_shifter;
  localparam int W = 82;
`ifdef PANEL_OUT_PARITY_EN
  localparam int NB    = W + 1;
  localparam int BUSY4 = 668;
  localparam int BUSY1 = 167;
`else
  localparam int NB    = W;
  localparam int BUSY4 = 660;
  localparam int BUSY1 = 165;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  panel_out_shifter_if #(.WIDTH(W)) if4 ();
  panel_out_shifter_if #(.WIDTH(W)) if1 ();

  panel_out_shifter #(.WIDTH(W), .CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  panel_out_shifter #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int total = 0;
  int bad = 0;
  int done1_cnt = 0;
  bit sel = 1'b0;
  logic [W-1:0]  last4;
  logic [NB-1:0] cap_bits;
  logic m_busy, m_done, m_sclk, m_sdata, m_latch;

  assign m_busy  = sel ? if1.busy_o  : if4.busy_o;
  assign m_done  = sel ? if1.done_o  : if4.done_o;
  assign m_sclk  = sel ? if1.sclk_o  : if4.sclk_o;
  assign m_sdata = sel ? if1.sdata_o : if4.sdata_o;
  assign m_latch = sel ? if1.latch_o : if4.latch_o;

  always @(negedge clk) if (if1.done_o === 1'b1) done1_cnt <= done1_cnt + 1;

  typedef struct {
    logic [W-1:0] data;
    bit           frc;
    int           exp_busy;
    string        nm;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference frame: payload MSB first, optionally followed by an even-parity bit.
  function automatic logic [NB-1:0] model_frame(input logic [W-1:0] d);
`ifdef PANEL_OUT_PARITY_EN
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    return {d, (ones % 2) == 1};
`else
    return d;
`endif
  endfunction

  task automatic run_frame(input string nm, input logic [W-1:0] d, input int exp_lat,
                           input int exp_busy);
    logic [NB-1:0] bits = '0;
    int lat = 0, blen = 0, nr = 0, llen = 0, lbad = 0, dmid = 0;
    logic prev = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_busy !== 1'b1 && lat < 40);
    chk({nm, "_lat"}, lat, exp_lat);
    if (m_busy !== 1'b1) return;
    while (m_busy === 1'b1 && blen < 20000) begin
      blen++;
      if (m_sclk === 1'b1 && prev === 1'b0) begin
        bits = {bits[NB-2:0], m_sdata};
        nr++;
      end
      if (m_latch === 1'b1) begin
        llen++;
        if (m_sdata !== 1'b0 || m_sclk !== 1'b0) lbad++;
      end
      if (m_done === 1'b1) dmid++;
      prev = m_sclk;
      @(negedge clk);
    end
    cap_bits = bits;
    chk({nm, "_busy_len"}, blen, exp_busy);
    chk({nm, "_rises"}, nr, NB);
    chk({nm, "_frame"}, bits, model_frame(d));
    chk({nm, "_latch_len"}, llen, sel ? 1 : 4);
    chk({nm, "_latch_pins"}, lbad, 0);
    chk({nm, "_done_early"}, dmid, 0);
    chk({nm, "_done"}, m_done, 1'b1);
  endtask

  task automatic idle_watch(input string nm, input int n);
    int edges = 0, nbusy = 0;
    logic p;
    @(negedge clk);
    p = if4.sclk_o;
    repeat (n) begin
      @(negedge clk);
      if (if4.sclk_o !== p) edges++;
      if (if4.busy_o !== 1'b0) nbusy++;
      p = if4.sclk_o;
    end
    chk({nm, "_sclk_edges"}, edges, 0);
    chk({nm, "_busy"}, nbusy, 0);
  endtask

  task automatic apply(input string nm, input logic [W-1:0] d, input bit f, input int exp_busy);
    @(posedge clk);
    #1 if4.data_i = d; if4.force_i = f;
    @(posedge clk);
    #1 if4.force_i = 1'b0;
    if (d !== last4 || f) begin
      run_frame(nm, d, 1, exp_busy);
      last4 = d;
    end else begin
      idle_watch(nm, 10);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t1, t4, d0, d1, d6, nd;
    logic [95:0]  r;
    int n0, nb;
    bit rep, f;

    t1 = 82'h22ee_22ee_33ff_33ff;
    t4 = 82'h3_0000_dead_beef_0000_1234;
    d0 = 82'h1_2345_6789_abcd_ef01_2340;
    d1 = d0 | 82'h5;

    tbl[0] = '{t1, 1'b1, BUSY4, "force_same"};
    tbl[1] = '{'0, 1'b0, BUSY4, "zeros"};
    tbl[2] = '{'0, 1'b1, BUSY4, "zeros_forced"};
    tbl[3] = '{'1, 1'b0, BUSY4, "ones"};
    tbl[4] = '{82'h1, 1'b0, BUSY4, "lsb1"};
    tbl[5] = '{82'h3, 1'b0, BUSY4, "lsb3"};
    tbl[6] = '{{1'b1, 81'b0}, 1'b0, BUSY4, "msb"};
    tbl[7] = '{{41{2'b10}}, 1'b0, BUSY4, "alt"};
    tbl[8] = '{{41{2'b10}}, 1'b0, 0, "alt_repeat"};

    rst = 1'b0;
    if4.data_i = '0; if4.force_i = 1'b0;
    if1.data_i = '0; if1.force_i = 1'b0;
    last4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", if4.busy_o, 1'b0);
    chk("rst_done", if4.done_o, 1'b0);
    chk("rst_sclk", if4.sclk_o, 1'b0);
    chk("rst_sdata", if4.sdata_o, 1'b0);
    chk("rst_latch", if4.latch_o, 1'b0);

    // reset release with a nonzero vector
    @(posedge clk);
    #1 if4.data_i = t1; rst = 1'b1;
    run_frame("t1", t1, 2, BUSY4);
    last4 = t1;

    idle_watch("t2_hold", 2000);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].nm, tbl[i].data, tbl[i].frc, tbl[i].exp_busy);
`ifdef PANEL_OUT_PARITY_EN
      if (tbl[i].data == 82'h1) chk("par_lsb1_final", cap_bits[0], 1'b1);
      if (tbl[i].data == 82'h3) chk("par_lsb3_final", cap_bits[0], 1'b0);
`endif
    end

    // change during a frame is deferred to the next frame
    @(posedge clk);
    #1 if4.data_i = d0;
    fork
      begin
        run_frame("t3_old", d0, 2, BUSY4);
        run_frame("t3_new", d1, 1, BUSY4);
      end
      begin
        repeat (200) @(posedge clk);
        #1 if4.data_i = d1;
      end
    join
    last4 = d1;

    // reset in the middle of a frame
    @(posedge clk);
    #1 if4.data_i = t4;
    repeat (300) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t4_busy", if4.busy_o, 1'b0);
    chk("t4_done", if4.done_o, 1'b0);
    chk("t4_sclk", if4.sclk_o, 1'b0);
    chk("t4_sdata", if4.sdata_o, 1'b0);
    chk("t4_latch", if4.latch_o, 1'b0);
    nb = 0;
    repeat (3) begin
      @(negedge clk);
      if (if4.latch_o !== 1'b0 || if4.busy_o !== 1'b0) nb++;
    end
    chk("t4_held", nb, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_frame("t4_after", t4, 2, BUSY4);
    last4 = t4;

    // CLK_DIV=1 with force held: back-to-back frames
    sel = 1'b1;
    r = {$urandom, $urandom, $urandom};
    d6 = r[W-1:0];
    n0 = done1_cnt;
    @(posedge clk);
    #1 if1.data_i = d6; if1.force_i = 1'b1;
    run_frame("t6_f0", d6, 2, BUSY1);
    run_frame("t6_f1", d6, 1, BUSY1);
    fork
      run_frame("t6_f2", d6, 1, BUSY1);
      begin
        repeat (10) @(posedge clk);
        #1 if1.force_i = 1'b0;
      end
    join
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (if1.busy_o !== 1'b0) nb++;
    end
    chk("t6_stop", nb, 0);
    chk("t6_dones", done1_cnt - n0, 3);
    sel = 1'b0;

    // randomized vectors, sometimes repeating the last one
    for (int k = 0; k < 8; k++) begin
      rep = ($urandom_range(0, 2) == 0);
      f = $urandom_range(0, 1) == 1;
      r = {$urandom, $urandom, $urandom};
      nd = rep ? last4 : r[W-1:0];
      apply($sformatf("rnd%0d", k), nd, f, BUSY4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
